// File: rtl/param_seq_alu_if.sv
// Handshake and operand/result bundle for param_seq_alu.
// The master drives Start/operands/ctrl; the ALU (slave) returns result, flags, Busy and Done.
interface param_seq_alu_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] Result;
    logic             Overflow;
    logic             Carry;
    logic             Zero;
    logic             Negative;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, opA, opB, ctrl,
        input  Result, Overflow, Carry, Zero, Negative, Busy, Done
    );

    modport slave (
        input  Start, opA, opB, ctrl,
        output Result, Overflow, Carry, Zero, Negative, Busy, Done
    );
endinterface

// File: rtl/param_seq_alu.sv
// Registered, parametrised ALU with Start/Busy/Done handshake, status flags and
// an iterative shift-add multiplier that retires one multiplier bit per cycle.
module param_seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    param_seq_alu_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt_p0;

    logic [WIDTH-1:0]     a_p0;
    logic [WIDTH-1:0]     b_p0;
    logic [2:0]           op_p0;
    logic [2*WIDTH-1:0]   acc_p0;
    logic [2*WIDTH-1:0]   mcand_p0;
    logic [WIDTH-1:0]     mplier_p0;

    logic [WIDTH-1:0]     result_p1;
    logic                 ovf_p1;
    logic                 carry_p1;
    logic                 zero_p1;
    logic                 neg_p1;
    logic                 busy_p1;
    logic                 vld_p1;

    logic [2*WIDTH-1:0]   partial;
    logic [WIDTH+1:0]     exec_res;
    logic [WIDTH:0]       mul_res;
    logic                 accept;
    logic                 mul_last;

    // Returns {overflow, carry, result} for every single-cycle op.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH:0]          sum;
        logic [WIDTH-1:0]        r;
        logic                    c;
        logic                    v;
        sa  = $signed(a);
        sb  = $signed(b);
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // A + ~B + 1, so the carry out reads as "no borrow".
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: r = '0;
        endcase
        return {v, c, r};
    endfunction

    // Returns {overflow, low product} from the full double-width product.
    function automatic logic [WIDTH:0] mul_finish(input logic [2*WIDTH-1:0] prod);
        return {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
    endfunction

    always_comb begin
        partial  = mplier_p0[0] ? mcand_p0 : '0;
        exec_res = alu_eval(a_p0, b_p0, op_p0);
        mul_res  = mul_finish(acc_p0 + partial);
        accept   = (state == IDLE) && bus.Start;
        mul_last = (cnt_p0 == CNT_W'(WIDTH - 1));
    end

    // ---- stage p0: operand latch and multiplier datapath ----
    always_ff @(posedge Clk) begin
        if (accept) begin
            a_p0      <= bus.opA;
            b_p0      <= bus.opB;
            op_p0     <= bus.ctrl;
            acc_p0    <= '0;
            mcand_p0  <= {{WIDTH{1'b0}}, bus.opA};
            mplier_p0 <= bus.opB;
        end else if (state == MUL) begin
            acc_p0    <= acc_p0 + partial;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    // ---- stage p1: FSM, registered result and flags ----
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt_p0    <= '0;
            result_p1 <= '0;
            ovf_p1    <= 1'b0;
            carry_p1  <= 1'b0;
            zero_p1   <= 1'b0;
            neg_p1    <= 1'b0;
            busy_p1   <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        busy_p1 <= 1'b1;
                        cnt_p0  <= '0;
                        state   <= (bus.ctrl == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    result_p1 <= exec_res[WIDTH-1:0];
                    carry_p1  <= exec_res[WIDTH];
                    ovf_p1    <= exec_res[WIDTH+1];
                    zero_p1   <= (exec_res[WIDTH-1:0] == '0);
                    neg_p1    <= exec_res[WIDTH-1];
                    busy_p1   <= 1'b0;
                    vld_p1    <= 1'b1;
                    state     <= IDLE;
                end
                MUL: begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                    if (mul_last) begin
                        result_p1 <= mul_res[WIDTH-1:0];
                        ovf_p1    <= mul_res[WIDTH];
                        carry_p1  <= 1'b0;
                        zero_p1   <= (mul_res[WIDTH-1:0] == '0);
                        neg_p1    <= mul_res[WIDTH-1];
                        busy_p1   <= 1'b0;
                        vld_p1    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Result   = result_p1;
    assign bus.Overflow = ovf_p1;
    assign bus.Carry    = carry_p1;
    assign bus.Zero     = zero_p1;
    assign bus.Negative = neg_p1;
    assign bus.Busy     = busy_p1;
    assign bus.Done     = vld_p1;
endmodule

// File: tb/tb_param_seq_alu.sv
// Directed bench for param_seq_alu: a WIDTH=4 instance for most ops and a WIDTH=8 instance for SLT/MUL edge cases.
module tb_param_seq_alu;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    param_seq_alu_if #(.WIDTH(4)) if4 ();
    param_seq_alu_if #(.WIDTH(8)) if8 ();

    param_seq_alu #(.WIDTH(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(if4.slave));
    param_seq_alu #(.WIDTH(8)) dut8 (.Clk(Clk), .Rst(Rst), .bus(if8.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] res_of(input bit w8);
        return w8 ? 32'(if8.Result) : 32'(if4.Result);
    endfunction
    function automatic logic done_of(input bit w8);
        return w8 ? if8.Done : if4.Done;
    endfunction
    function automatic logic busy_of(input bit w8);
        return w8 ? if8.Busy : if4.Busy;
    endfunction

    // Drives one request for a single cycle; returns #1 after the accepting edge.
    task automatic issue(input bit w8, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        if (w8) begin
            if8.Start = 1'b1; if8.ctrl = c; if8.opA = a; if8.opB = b;
        end else begin
            if4.Start = 1'b1; if4.ctrl = c; if4.opA = a[3:0]; if4.opB = b[3:0];
        end
        @(posedge Clk); #1;
        if4.Start = 1'b0;
        if8.Start = 1'b0;
    endtask

    task automatic wait_done(input bit w8, output int n);
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!done_of(w8) && n < 50);
    endtask

    task automatic chk_out(input string tag, input bit w8, input logic [31:0] r,
                           input logic v, input logic c, input logic z, input logic ng);
        chk({tag, "_res"}, res_of(w8), r);
        chk({tag, "_ovf"}, w8 ? if8.Overflow : if4.Overflow, v);
        chk({tag, "_cry"}, w8 ? if8.Carry : if4.Carry, c);
        chk({tag, "_zero"}, w8 ? if8.Zero : if4.Zero, z);
        chk({tag, "_neg"}, w8 ? if8.Negative : if4.Negative, ng);
        chk({tag, "_busy"}, busy_of(w8), 1'b0);
    endtask

    initial begin
        int n;
        int dones;
        logic [31:0] seen;

        if4.Start = 1'b0; if4.ctrl = '0; if4.opA = '0; if4.opB = '0;
        if8.Start = 1'b0; if8.ctrl = '0; if8.opA = '0; if8.opB = '0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        chk("rst_busy", if4.Busy, 1'b0);
        chk("rst_done", if4.Done, 1'b0);
        chk("rst_res", if4.Result, 4'h0);

        // ADD 0111+0001: signed overflow into negative
        issue(0, 3'b001, 8'h7, 8'h1);
        chk("add_busy", if4.Busy, 1'b1);
        wait_done(0, n);
        chk("add_lat", n, 1);
        chk_out("add", 0, 4'h8, 1, 0, 0, 1);
        @(posedge Clk); #1;
        chk("add_done_pulse", if4.Done, 1'b0);
        chk("add_hold", if4.Result, 4'h8);

        // Asynchronous reset between edges clears outputs at once
        Rst = 1'b1;
        #1;
        chk("arst_res", if4.Result, 4'h0);
        chk("arst_ovf", if4.Overflow, 1'b0);
        chk("arst_neg", if4.Negative, 1'b0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("arst_busy", if4.Busy, 1'b0);
        chk("arst_done", if4.Done, 1'b0);

        issue(0, 3'b011, 8'h3, 8'h5);
        wait_done(0, n);
        chk("sub1_lat", n, 1);
        chk_out("sub1", 0, 4'hE, 0, 0, 0, 1);

        issue(0, 3'b011, 8'h5, 8'h5);
        wait_done(0, n);
        chk_out("sub0", 0, 4'h0, 0, 1, 1, 0);

        issue(0, 3'b010, 8'h9, 8'h4);
        wait_done(0, n);
        chk_out("or", 0, 4'hD, 0, 0, 0, 1);

        issue(0, 3'b100, 8'hF, 8'h6);
        wait_done(0, n);
        chk_out("xor", 0, 4'h9, 0, 0, 0, 1);

        issue(0, 3'b101, 8'h5, 8'h3);
        chk("mul1_busy", if4.Busy, 1'b1);
        wait_done(0, n);
        chk("mul1_lat", n, 4);
        chk_out("mul1", 0, 4'hF, 0, 0, 0, 1);

        issue(0, 3'b101, 8'h6, 8'h5);
        wait_done(0, n);
        chk("mul2_lat", n, 4);
        chk_out("mul2", 0, 4'hE, 1, 0, 0, 1);

        // AND request and operand changes while the multiplier is busy
        issue(0, 3'b101, 8'h5, 8'h3);
        issue(0, 3'b000, 8'hC, 8'hA);
        if4.opA = 4'h0; if4.opB = 4'h0;
        dones = 0;
        seen  = '0;
        for (int i = 0; i < 10; i++) begin
            if (if4.Done) begin
                dones++;
                seen = 32'(if4.Result);
            end
            @(posedge Clk); #1;
        end
        chk("ign_dones", dones, 1);
        chk("ign_res", seen, 4'hF);

        // Start on the Done cycle is accepted
        issue(0, 3'b101, 8'h6, 8'h5);
        wait_done(0, n);
        chk("b2b_mul_res", if4.Result, 4'hE);
        issue(0, 3'b000, 8'hC, 8'hA);
        chk("b2b_busy", if4.Busy, 1'b1);
        chk("b2b_done_low", if4.Done, 1'b0);
        wait_done(0, n);
        chk("b2b_lat", n, 1);
        chk_out("b2b_and", 0, 4'h8, 0, 0, 0, 1);

        // Reset during MUL cycle 2 aborts without Done
        issue(0, 3'b101, 8'h7, 8'h7);
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        chk("abort_busy", if4.Busy, 1'b0);
        chk("abort_res", if4.Result, 4'h0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (if4.Done) dones++;
            @(posedge Clk); #1;
        end
        chk("abort_dones", dones, 0);
        issue(0, 3'b001, 8'h2, 8'h3);
        wait_done(0, n);
        chk_out("post_add", 0, 4'h5, 0, 0, 0, 0);

        issue(0, 3'b111, 8'hF, 8'hF);
        wait_done(0, n);
        chk("rsvd_lat", n, 1);
        chk_out("rsvd", 0, 4'h0, 0, 0, 1, 0);

        issue(1, 3'b110, 8'hFF, 8'h01);
        wait_done(1, n);
        chk("slt_lat", n, 1);
        chk_out("slt_lt", 1, 8'h01, 0, 0, 0, 0);

        issue(1, 3'b110, 8'h01, 8'hFF);
        wait_done(1, n);
        chk_out("slt_ge", 1, 8'h00, 0, 0, 1, 0);

        issue(1, 3'b101, 8'h10, 8'h10);
        wait_done(1, n);
        chk("mul8_lat", n, 8);
        chk_out("mul8", 1, 8'h00, 1, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. Operand width is generic, and the op set adds OR, XOR, signed compare and a multi-cycle shift-add multiply. It adds status flags and a Start/Busy/Done handshake. It sits between the operand registers and the datapath result bus in the lab processor datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2 to 32).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- opA  input  WIDTH  operand A.
- opB  input  WIDTH  operand B.
- ctrl  input  3  operation select; sampled with Start.
- Result  output  WIDTH  registered result.
- Overflow  output  1  registered overflow flag.
- Carry  output  1  registered carry / not-borrow flag.
- Zero  output  1  registered flag: Result equals 0.
- Negative  output  1  registered copy of Result[WIDTH-1].
- Busy  output  1  high while an accepted op is in progress.
- Done  output  1  single-cycle pulse when Result and flags update.

Behaviour:
- Reset (asynchronous, any state, including mid-multiply):
  - All outputs go to 0 and the FSM returns to IDLE.
  - An aborted op never produces Done.
- ctrl encoding:
  - 000 AND
  - 001 ADD
  - 010 OR
  - 011 SUB (A-B)
  - 100 XOR
  - 101 MUL (unsigned)
  - 110 SLT (signed A<B gives Result=1, else 0)
  - 111 reserved: Result=0, all flags 0, Done still pulses.
- FSM states: IDLE, EXEC, MUL.
  - IDLE with Start=1 at edge N: latch opA, opB, ctrl and set Busy=1. Go to MUL if ctrl=101, otherwise to EXEC.
  - EXEC at edge N+1: write Result and flags, Busy=0, Done=1, go to IDLE. Latency is 1 cycle after acceptance.
  - MUL: iterative shift-add, one multiplier bit per cycle. At edge N+WIDTH write Result and flags, Busy=0, Done=1, go to IDLE. Latency is WIDTH cycles.
- Done is high for exactly one cycle and coincides with the first IDLE cycle.
  - Start in that cycle is accepted, so back-to-back ops are possible.
- Start while Busy=1 is ignored. Latched operands are not disturbed by input changes during Busy.
- Result and flags hold their values between Done pulses.
- Arithmetic rules:
  - ADD: Carry is the carry out of bit WIDTH-1. Overflow is signed two's-complement overflow.
  - SUB: computed as A+~B+1. Carry is that carry out (1 means no borrow). Overflow is signed overflow.
  - MUL: Result is the low WIDTH bits of the 2*WIDTH product. Overflow=1 if the high WIDTH bits are nonzero. Carry=0.
  - AND, OR, XOR, SLT: Carry=0, Overflow=0.
- Zero and Negative are derived from the new Result for every op, including reserved.

Test Plan:
- Reset then idle: Rst=1 mid-run gives all outputs 0 immediately (no clock edge); after release, Busy=0 and Done=0.
- WIDTH=4, ADD 0111+0001: after 1 cycle Result=1000, Overflow=1, Negative=1, Carry=0, Zero=0, one Done pulse.
- WIDTH=4, SUB 0011-0101: Result=1110, Carry=0, Overflow=0, Negative=1.
- WIDTH=4, SUB 0101-0101: Result=0000, Zero=1, Carry=1.
- WIDTH=4, MUL 0101*0011: Busy for 4 cycles, then Result=1111, Overflow=0.
- WIDTH=4, MUL 0110*0101: Result=1110, Overflow=1.
- Start pulsed with AND during a MUL is ignored; MUL result is unchanged and there is exactly one Done.
- Start asserted on the Done cycle of a MUL, with AND 1100&1010: accepted, and the next Done shows Result=1000.
- Rst asserted at MUL cycle 2: no Done, outputs 0, and a new ADD 0010+0011 afterwards gives Result=0101.
- WIDTH=8, SLT 0xFF (-1) vs 0x01: Result=0x01. With A and B swapped: Result=0x00, Zero=1.
